ru_writeback_unit: RTL and testbench

- Sequential write-back unit for the rv32i core. It closes the datapath loop opposite the ALU operand muxes.
- It takes the retiring instruction's result source (ALU result, data-memory load, or PC+4) and performs the data-memory read for loads, including byte/half extraction and sign or zero extension.
- It drives the register-unit write port and asserts a stall toward the PC/control while a write-back is in flight.

---
 rtl/ru_writeback_unit.sv | 204 ++++++++++++++++++++
 tb/tb_ru_writeback_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ru_writeback_unit.sv
// rv32i write-back unit: selects the retiring result (ALU, load, PC+4), performs
// the data-memory read with byte/half extraction, and drives the register write port.
module ru_writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        ruWr,
  input  logic [1:0]  ruDataWrSrc,
  input  logic [2:0]  dmCtrl,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_res,
  input  logic [31:0] pc_inc,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic        ru_we,
  output logic [4:0]  ru_rd,
  output logic [31:0] ru_wdata,
  output logic        stall,
  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

  state_t r_state, w_state_nxt;

  // Latched instruction context and in-flight data
  logic [4:0]       r_rd,   w_rd_nxt;
  logic             r_wr,   w_wr_nxt;
  logic [2:0]       r_ctrl, w_ctrl_nxt;
  logic [1:0]       r_off,  w_off_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic [CNT_W-1:0] r_cnt,  w_cnt_nxt;

  // Registered outputs
  logic        r_mem_re,   w_mem_re_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic        r_ru_we,    w_ru_we_nxt;
  logic [4:0]  r_ru_rd,    w_ru_rd_nxt;
  logic [31:0] r_ru_wdata, w_ru_wdata_nxt;
  logic        r_stall,    w_stall_nxt;
  logic        r_err_mis,  w_err_mis_nxt;
  logic        r_err_to,   w_err_to_nxt;

  logic             w_is_load;
  logic             w_misaligned;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic [31:0]      w_load_data;

  function automatic logic [31:0] extract(input logic [2:0] ctrl, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (ctrl)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = word;
    endcase
  endfunction

  assign w_is_load   = (ruDataWrSrc == 2'b01);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_timeout   = (w_cnt_inc == CNT_W'(MEM_TIMEOUT));
  assign w_load_data = extract(r_ctrl, r_off, mem_rdata);

  // Undefined load types behave as LW, including the alignment rule
  always_comb begin
    w_misaligned = 1'b0;
    case (dmCtrl)
      3'b000, 3'b100: w_misaligned = 1'b0;
      3'b001, 3'b101: w_misaligned = alu_res[0];
      default:        w_misaligned = (alu_res[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          if (!w_is_load)         w_state_nxt = S_WRITE;
          else if (!w_misaligned) w_state_nxt = S_REQ;
        end
      end
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid)     w_state_nxt = S_WRITE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_nxt       = r_rd;
    w_wr_nxt       = r_wr;
    w_ctrl_nxt     = r_ctrl;
    w_off_nxt      = r_off;
    w_data_nxt     = r_data;
    w_cnt_nxt      = r_cnt;
    w_mem_re_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_ru_we_nxt    = 1'b0;
    w_ru_rd_nxt    = r_ru_rd;
    w_ru_wdata_nxt = r_ru_wdata;
    w_stall_nxt    = (w_state_nxt != S_IDLE);
    w_err_mis_nxt  = 1'b0;
    w_err_to_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_rd_nxt   = rd;
          w_wr_nxt   = ruWr;
          w_ctrl_nxt = dmCtrl;
          w_off_nxt  = alu_res[1:0];
          if (!w_is_load) begin
            w_data_nxt = (ruDataWrSrc == 2'b10) ? pc_inc : alu_res;
          end else if (w_misaligned) begin
            w_err_mis_nxt = 1'b1;
          end else begin
            w_mem_re_nxt   = 1'b1;
            w_mem_addr_nxt = {alu_res[31:2], 2'b00};
          end
        end
      end
      S_REQ: w_cnt_nxt = '0;
      S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (mem_rvalid)     w_data_nxt   = w_load_data;
        else if (w_timeout) w_err_to_nxt = 1'b1;
      end
      default: begin
        w_ru_we_nxt    = r_wr && (r_rd != 5'd0);
        w_ru_rd_nxt    = r_rd;
        w_ru_wdata_nxt = r_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd       <= '0;
      r_wr       <= 1'b0;
      r_ctrl     <= '0;
      r_off      <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_mem_re   <= 1'b0;
      r_mem_addr <= '0;
      r_ru_we    <= 1'b0;
      r_ru_rd    <= '0;
      r_ru_wdata <= '0;
      r_stall    <= 1'b0;
      r_err_mis  <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_off      <= w_off_nxt;
      r_data     <= w_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mem_re   <= w_mem_re_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_ru_we    <= w_ru_we_nxt;
      r_ru_rd    <= w_ru_rd_nxt;
      r_ru_wdata <= w_ru_wdata_nxt;
      r_stall    <= w_stall_nxt;
      r_err_mis  <= w_err_mis_nxt;
      r_err_to   <= w_err_to_nxt;
    end
  end

  assign mem_re         = r_mem_re;
  assign mem_addr       = r_mem_addr;
  assign ru_we          = r_ru_we;
  assign ru_rd          = r_ru_rd;
  assign ru_wdata       = r_ru_wdata;
  assign stall          = r_stall;
  assign err_misaligned = r_err_mis;
  assign err_timeout    = r_err_to;

endmodule

// File: tb/tb_ru_writeback_unit.sv
// Directed self-checking bench for ru_writeback_unit.
module tb_ru_writeback_unit;

  logic        clk = 1'b0;
  logic        rst, valid_in, ruWr, mem_rvalid;
  logic [1:0]  ruDataWrSrc;
  logic [2:0]  dmCtrl;
  logic [4:0]  rd;
  logic [31:0] alu_res, pc_inc, mem_rdata;
  logic        mem_re, ru_we, stall, err_misaligned, err_timeout;
  logic [31:0] mem_addr, ru_wdata;
  logic [4:0]  ru_rd;

  int checks = 0;
  int errors = 0;

  ru_writeback_unit #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ruWr(ruWr), .ruDataWrSrc(ruDataWrSrc),
    .dmCtrl(dmCtrl), .rd(rd), .alu_res(alu_res), .pc_inc(pc_inc), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_re(mem_re), .mem_addr(mem_addr), .ru_we(ru_we),
    .ru_rd(ru_rd), .ru_wdata(ru_wdata), .stall(stall), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-load: write visible one cycle after acceptance
  task automatic do_alu(input string tag, input logic [1:0] src, input logic [4:0] rdi,
                        input logic [31:0] alu, input logic [31:0] pci, input logic [31:0] exp);
    ruDataWrSrc = src; rd = rdi; ruWr = 1'b1; alu_res = alu; pc_inc = pci; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk({tag, "_stall"}, 32'(stall), 32'd1);
    chk({tag, "_we0"}, 32'(ru_we), 32'd0);
    tick();
    chk({tag, "_we"}, 32'(ru_we), 32'd1);
    chk({tag, "_rd"}, 32'(ru_rd), 32'(rdi));
    chk({tag, "_data"}, ru_wdata, exp);
    chk({tag, "_stall_off"}, 32'(stall), 32'd0);
    tick();
    chk({tag, "_we_pulse"}, 32'(ru_we), 32'd0);
  endtask

  // Load with rvalid in the first WAIT cycle: write three cycles after acceptance
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] ctrl,
                         input logic [4:0] rdi, input logic [31:0] word, input logic [31:0] exp);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    ruDataWrSrc = 2'b01; dmCtrl = ctrl; rd = rdi; ruWr = 1'b1; alu_res = addr; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk({tag, "_re"}, 32'(mem_re), 32'd1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    tick();
    chk({tag, "_re_pulse"}, 32'(mem_re), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = word;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_we_early"}, 32'(ru_we), 32'd0);
    tick();
    chk({tag, "_we"}, 32'(ru_we), 32'd1);
    chk({tag, "_data"}, ru_wdata, exp);
    chk({tag, "_rd"}, 32'(ru_rd), 32'(rdi));
    tick();
    chk({tag, "_we_pulse"}, 32'(ru_we), 32'd0);
  endtask

  task automatic do_misaligned(input string tag, input logic [31:0] addr, input logic [2:0] ctrl);
    ruDataWrSrc = 2'b01; dmCtrl = ctrl; rd = 5'd4; ruWr = 1'b1; alu_res = addr; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk({tag, "_err"}, 32'(err_misaligned), 32'd1);
    chk({tag, "_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    tick();
    chk({tag, "_err_pulse"}, 32'(err_misaligned), 32'd0);
    chk({tag, "_we"}, 32'(ru_we), 32'd0);
  endtask

  initial begin
    int n_we, n_re;
    rst = 1'b1; valid_in = 1'b0; ruWr = 1'b0; mem_rvalid = 1'b0; ruDataWrSrc = 2'b00;
    dmCtrl = 3'b000; rd = 5'd0; alu_res = '0; pc_inc = '0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_we", 32'(ru_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_wdata", ru_wdata, 32'd0);

    do_alu("alu", 2'b00, 5'd5, 32'h0000_1234, 32'h0000_0999, 32'h0000_1234);
    do_alu("jal", 2'b10, 5'd1, 32'h0000_DEAD, 32'h0000_0044, 32'h0000_0044);
    do_alu("rsv", 2'b11, 5'd2, 32'h0000_0777, 32'h0000_0044, 32'h0000_0777);

    do_load("lb",  32'h0000_0103, 3'b000, 5'd7,  32'h80FF_1122, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0103, 3'b100, 5'd8,  32'h80FF_1122, 32'h0000_0080);
    do_load("lb1", 32'h0000_0101, 3'b000, 5'd8,  32'h80FF_1122, 32'h0000_0011);
    do_load("lh",  32'h0000_0202, 3'b001, 5'd10, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lhu", 32'h0000_0200, 3'b101, 5'd11, 32'h1234_ABCD, 32'h0000_ABCD);
    do_load("lw",  32'h0000_0300, 3'b010, 5'd12, 32'hCAFE_BABE, 32'hCAFE_BABE);
    do_load("ldx", 32'h0000_0304, 3'b110, 5'd13, 32'h8765_4321, 32'h8765_4321);

    do_misaligned("mis_lhu", 32'h0000_0201, 3'b101);
    do_misaligned("mis_lw",  32'h0000_0302, 3'b010);

    // Timeout: 16 WAIT cycles without rvalid
    ruDataWrSrc = 2'b01; dmCtrl = 3'b010; rd = 5'd9; ruWr = 1'b1; alu_res = 32'h400; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), {30'd0, stall, err_timeout}, 32'd2);
    end
    tick();
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_we", 32'(ru_we), 32'd0);
    tick();
    chk("to_err_pulse", 32'(err_timeout), 32'd0);

    // rvalid in the final WAIT cycle beats the timeout
    alu_res = 32'h404; rd = 5'd14; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 1; i <= 16; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("race_err", 32'(err_timeout), 32'd0);
    tick();
    chk("race_we", 32'(ru_we), 32'd1);
    chk("race_data", ru_wdata, 32'h0BAD_F00D);

    // Reset during WAIT, then a late rvalid in IDLE
    alu_res = 32'h500; rd = 5'd15; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wdata", ru_wdata, 32'd0);
    chk("mid_rst_rd", 32'(ru_rd), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick(); tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_we", 32'(ru_we), 32'd0);
    chk("late_rvalid_stall", 32'(stall), 32'd0);

    // rd = 0: full sequence, no write
    ruDataWrSrc = 2'b00; rd = 5'd0; alu_res = 32'h55; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("rd0_stall", 32'(stall), 32'd1);
    n_we = 0;
    for (int i = 0; i < 3; i++) begin tick(); n_we += int'(ru_we); end
    chk("rd0_we", 32'(n_we), 32'd0);

    // valid held high: non-load accepted every other cycle
    ruDataWrSrc = 2'b00; rd = 5'd3; alu_res = 32'h11; valid_in = 1'b1;
    n_we = 0;
    for (int i = 0; i < 6; i++) begin tick(); n_we += int'(ru_we); end
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); n_we += int'(ru_we); end
    chk("hold_alu_writes", 32'(n_we), 32'd3);

    // valid held high on loads with rvalid always high: one write and one read per load
    ruDataWrSrc = 2'b01; dmCtrl = 3'b010; rd = 5'd6; alu_res = 32'h600;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AB; valid_in = 1'b1;
    n_we = 0; n_re = 0;
    for (int i = 0; i < 8; i++) begin tick(); n_we += int'(ru_we); n_re += int'(mem_re); end
    valid_in = 1'b0; mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); n_we += int'(ru_we); n_re += int'(mem_re); end
    chk("hold_ld_writes", 32'(n_we), 32'd2);
    chk("hold_ld_reads", 32'(n_re), 32'd2);
    chk("hold_ld_data", ru_wdata, 32'h0000_00AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
